// File: rtl/deserialize.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a load/shift serial link
// and hands them to a parallel consumer through a one-entry valid/ready buffer.
module deserialize #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_shift,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [CW-1:0]    bit_count,
    output logic             partial_drop,
    output logic             overflow
);

    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             drain;

    always_comb begin
        // Word as it will look once the current bit is shifted in.
        if (MSB_FIRST) begin
            word = {shift_q[WIDTH-2:0], serial_in};
        end else begin
            word = {serial_in, shift_q[WIDTH-1:1]};
        end

        shift_d  = shift_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        drop_d   = 1'b0;
        ovf_d    = ovf_q;
        complete = 1'b0;
        drain    = valid_q & data_ready;

        if (load_shift) begin
            cnt_d  = '0;
            drop_d = (cnt_q != '0);
        end else begin
            shift_d = word;
            if (cnt_q == LastBit) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (complete) begin
            if (!valid_q || drain) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign bit_count    = cnt_q;
    assign partial_drop = drop_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_deserialize.sv
// Bench for deserialize: MSB-first and LSB-first instances share one stimulus stream and are
// compared every cycle against an arithmetic model of the receiver.
module tb_deserialize;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W);

    logic          clock = 1'b0;
    logic          reset, load_shift, serial_in, data_ready;
    logic [W-1:0]  data_m, data_l;
    logic          valid_m, valid_l, drop_m, drop_l, ovf_m, ovf_l;
    logic [CW-1:0] cnt_m, cnt_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: frame position and word values as plain integers.
    int m_cnt, m_acc_m, m_acc_l, m_data_m, m_data_l;
    bit m_valid, m_drop, m_ovf;

    always #5 clock = ~clock;

    deserialize #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clock), .reset(reset), .load_shift(load_shift), .serial_in(serial_in),
        .data_out(data_m), .data_valid(valid_m), .data_ready(data_ready),
        .bit_count(cnt_m), .partial_drop(drop_m), .overflow(ovf_m)
    );

    deserialize #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .load_shift(load_shift), .serial_in(serial_in),
        .data_out(data_l), .data_valid(valid_l), .data_ready(data_ready),
        .bit_count(cnt_l), .partial_drop(drop_l), .overflow(ovf_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input bit s, input bit d);
        bit drain, complete;
        if (r) begin
            m_cnt = 0; m_acc_m = 0; m_acc_l = 0; m_data_m = 0; m_data_l = 0;
            m_valid = 0; m_drop = 0; m_ovf = 0;
            return;
        end
        drain    = m_valid && d;
        complete = 0;
        m_drop   = 0;
        if (l) begin
            m_drop = (m_cnt != 0);
            m_cnt  = 0;
        end else begin
            if (m_cnt == 0) begin
                m_acc_m = 0;
                m_acc_l = 0;
            end
            m_acc_m = m_acc_m * 2 + int'(s);
            m_acc_l = m_acc_l + (int'(s) << m_cnt);
            m_cnt++;
            if (m_cnt == W) begin
                complete = 1;
                m_cnt    = 0;
            end
        end
        if (complete) begin
            if (!m_valid || drain) begin
                m_data_m = m_acc_m;
                m_data_l = m_acc_l;
                m_valid  = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (drain) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("msb_data",  32'(data_m),  32'(m_data_m));
        check("lsb_data",  32'(data_l),  32'(m_data_l));
        check("msb_valid", 32'(valid_m), 32'(m_valid));
        check("lsb_valid", 32'(valid_l), 32'(m_valid));
        check("msb_count", 32'(cnt_m),   32'(m_cnt));
        check("lsb_count", 32'(cnt_l),   32'(m_cnt));
        check("msb_drop",  32'(drop_m),  32'(m_drop));
        check("lsb_drop",  32'(drop_l),  32'(m_drop));
        check("msb_ovf",   32'(ovf_m),   32'(m_ovf));
        check("lsb_ovf",   32'(ovf_l),   32'(m_ovf));
    endtask

    task automatic step(input bit r, input bit l, input bit s, input bit d);
        reset      = r;
        load_shift = l;
        serial_in  = s;
        data_ready = d;
        @(posedge clock);
        model_edge(r, l, s, d);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit d);
        logic [W-1:0] v;
        v = w;
        for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b0, v[i], d);
    endtask

    initial begin
        reset = 1'b1; load_shift = 1'b0; serial_in = 1'b0; data_ready = 1'b0;

        // T1: reset, one load cycle, 1011 with ready high.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_valid", 32'(valid_m), 32'd0);
        check("reset_data",  32'(data_m),  32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        send_word(4'b1011, 1'b1);
        check("t1_msb_word", 32'(data_m), 32'hB);
        check("t1_lsb_word", 32'(data_l), 32'hD);
        check("t1_valid",    32'(valid_m), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("t1_valid_pulse", 32'(valid_m), 32'd0);

        // T2: back-to-back words with no load between them.
        send_word(4'b1011, 1'b1);
        send_word(4'b0110, 1'b1);
        check("t2_word2", 32'(data_m), 32'h6);

        // T3: consumer stalled, second word overflows, then one accept.
        step(1'b0, 1'b1, 1'b0, 1'b1);
        send_word(4'b1011, 1'b0);
        send_word(4'b0001, 1'b0);
        check("t3_kept", 32'(data_m), 32'hB);
        check("t3_ovf",  32'(ovf_m),  32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_drained", 32'(valid_m), 32'd0);

        // T4: partial frame aborted by load.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_drop", 32'(drop_m), 32'd1);
        send_word(4'b0101, 1'b1);
        check("t4_word", 32'(data_m), 32'h5);

        // T5: completion and drain on the same edge.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'hB, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_word",  32'(data_m),  32'h3);
        check("t5_valid", 32'(valid_m), 32'd1);
        check("t5_ovf",   32'(ovf_m),   32'd0);

        // T6: reset mid-frame with a word pending.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_valid", 32'(valid_m), 32'd0);
        check("t6_drop",  32'(drop_m),  32'd0);
        send_word(4'b1100, 1'b1);
        check("t6_word", 32'(data_m), 32'hC);

        // Random traffic: sparse loads and resets, random ready.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
